// File: rtl/auto_catch_player.sv
// auto_catch_player
//   Automated player for the LED catch game. Watches the game's LED bus for a
//   new one-hot target. After a reaction delay it presents the matching switch
//   pattern, or its complement when miss_mode is set. It then pulses the
//   active-low button and holds the pattern through a cooldown. An all-ones
//   LED bus means the game is lost; the player parks in LOST until it clears.
//
// Ports
//   Clk_50MHz  in   1   sole clock, rising edge
//   reset      in   1   asynchronous, active-low
//   enable     in   1   allow new presses to start
//   miss_mode  in   1   present the complemented pattern
//   LED        in  10   game LED bus (asynchronous)
//   SW         out 10   switch pattern to the game
//   button     out  1   active-low press strobe, idle high
//   presses    out  8   completed press count, wraps
//   busy       out  1   high outside IDLE and LOST
module auto_catch_player #(
  parameter int REACT_CYCLES    = 1000,
  parameter int PRESS_CYCLES    = 500,
  parameter int COOLDOWN_CYCLES = 2000
) (
  input  logic       Clk_50MHz,
  input  logic       reset,
  input  logic       enable,
  input  logic       miss_mode,
  input  logic [9:0] LED,
  output logic [9:0] SW,
  output logic       button,
  output logic [7:0] presses,
  output logic       busy
);

  // One shared down-counter, wide enough for the longest phase minus one.
  localparam int MAX_AB = (REACT_CYCLES > PRESS_CYCLES) ? REACT_CYCLES : PRESS_CYCLES;
  localparam int MAX_C  = (MAX_AB > COOLDOWN_CYCLES) ? MAX_AB : COOLDOWN_CYCLES;
  localparam int CNT_W  = (MAX_C > 2) ? $clog2(MAX_C) : 1;

  localparam logic [CNT_W-1:0] REACT_LD = CNT_W'(REACT_CYCLES - 1);
  localparam logic [CNT_W-1:0] PRESS_LD = CNT_W'(PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] COOL_LD  = CNT_W'(COOLDOWN_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_SETUP,
    ST_PRESS,
    ST_COOLDOWN,
    ST_LOST
  } state_t;

  state_t           state, state_n;
  logic [9:0]       led_m, led_s, led_p;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [9:0]       target, target_n;
  logic [9:0]       sw_pat, sw_pat_n;
  logic [7:0]       presses_q, presses_n;
  logic             lost_pend, lost_pend_n;

  logic one_hot, all_ones, target_evt;

  assign one_hot    = (led_s != 10'h000) && ((led_s & (led_s - 10'd1)) == 10'h000);
  assign all_ones   = (led_s == 10'h3FF);
  assign target_evt = (led_s != led_p) && one_hot;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge Clk_50MHz or negedge reset) begin
    if (!reset) begin
      led_m     <= '0;
      led_s     <= '0;
      led_p     <= '0;
      state     <= ST_IDLE;
      cnt       <= '0;
      target    <= '0;
      sw_pat    <= '0;
      presses_q <= '0;
      lost_pend <= 1'b0;
    end else begin
      led_m     <= LED;
      led_s     <= led_m;
      led_p     <= led_s;
      state     <= state_n;
      cnt       <= cnt_n;
      target    <= target_n;
      sw_pat    <= sw_pat_n;
      presses_q <= presses_n;
      lost_pend <= lost_pend_n;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    target_n    = target;
    sw_pat_n    = sw_pat;
    presses_n   = presses_q;
    lost_pend_n = lost_pend;

    unique case (state)
      // LOST shares IDLE's acquisition rule once the bus clears, so a target
      // that replaces the all-ones value is caught in the same cycle.
      ST_IDLE, ST_LOST: begin
        if (all_ones) begin
          state_n = ST_LOST;
        end else if (target_evt && enable) begin
          state_n  = ST_WAIT;
          target_n = led_s;
          cnt_n    = REACT_LD;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (all_ones) begin
          state_n = ST_LOST;
        end else if (!enable) begin
          state_n = ST_IDLE;
        end else if (target_evt) begin
          target_n = led_s;
          cnt_n    = REACT_LD;
        end else if (cnt == '0) begin
          state_n  = ST_SETUP;
          sw_pat_n = miss_mode ? ~target : target;
          cnt_n    = SETUP_LD;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      ST_SETUP: begin
        if (all_ones) begin
          state_n = ST_LOST;
        end else if (!enable) begin
          state_n = ST_IDLE;
        end else if (cnt == '0) begin
          state_n     = ST_PRESS;
          cnt_n       = PRESS_LD;
          lost_pend_n = 1'b0;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      // A press always runs to completion; an all-ones bus seen at any point
      // during it is remembered and redirects the exit to LOST.
      ST_PRESS: begin
        if (all_ones) lost_pend_n = 1'b1;
        if (cnt == '0) begin
          presses_n = presses_q + 8'd1;
          state_n   = (lost_pend || all_ones) ? ST_LOST : ST_COOLDOWN;
          cnt_n     = COOL_LD;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      ST_COOLDOWN: begin
        if (all_ones) begin
          state_n = ST_LOST;
        end else if (cnt == '0) begin
          state_n = ST_IDLE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Outputs decode directly from state, so an asynchronous reset takes them
  // to their idle values without waiting for a clock edge.
  assign SW      = (state == ST_SETUP || state == ST_PRESS || state == ST_COOLDOWN) ? sw_pat : '0;
  assign button  = (state != ST_PRESS);
  assign busy    = (state != ST_IDLE) && (state != ST_LOST);
  assign presses = presses_q;

endmodule

// File: tb/tb_auto_catch_player.sv
module tb_auto_catch_player;

  localparam int REACT = 4;
  localparam int PRESS = 3;
  localparam int COOL  = 5;
  // LED change -> two synchronizer stages -> IDLE->WAIT edge -> REACT wait
  // cycles -> two SETUP cycles; the first low button sample follows.
  localparam int LAT   = 2 + 1 + REACT + 2;

  logic       Clk_50MHz = 1'b0;
  logic       reset;
  logic       enable;
  logic       miss_mode;
  logic [9:0] LED;
  logic [9:0] SW;
  logic       button;
  logic [7:0] presses;
  logic       busy;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] pcount = 8'd0;  // reference press count

  always #5 Clk_50MHz = ~Clk_50MHz;

  auto_catch_player #(
    .REACT_CYCLES   (REACT),
    .PRESS_CYCLES   (PRESS),
    .COOLDOWN_CYCLES(COOL)
  ) dut (
    .Clk_50MHz(Clk_50MHz),
    .reset    (reset),
    .enable   (enable),
    .miss_mode(miss_mode),
    .LED      (LED),
    .SW       (SW),
    .button   (button),
    .presses  (presses),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    LED = 10'h000;
    repeat (3) @(negedge Clk_50MHz);
  endtask

  // Called right after the caller drives a new target onto LED at a negedge.
  // Follows one whole press transaction and compares it with the expected
  // timing, pattern and count.
  task automatic observe_press(input string tag, input logic [9:0] exp_sw,
                               input bit inject_lost, input bit flip_miss);
    int n, w, hold;
    logic [9:0] h1, h2, h3;
    bit to;
    n = 0; h1 = '0; h2 = '0; h3 = '0; to = 0;
    forever begin
      @(negedge Clk_50MHz);
      n++;
      if (button === 1'b0) break;
      h3 = h2; h2 = h1; h1 = SW;
      if (n >= 60) begin to = 1; break; end
    end
    if (to) begin
      check({tag, " fall_timeout"}, 32'd0, 32'd1);
      return;
    end
    check({tag, " latency"}, n, LAT);
    check({tag, " sw_setup1"}, h1, exp_sw);
    check({tag, " sw_setup2"}, h2, exp_sw);
    check({tag, " sw_before_setup"}, h3, 10'h000);
    check({tag, " sw_at_fall"}, SW, exp_sw);
    if (flip_miss) miss_mode = ~miss_mode;
    if (inject_lost) LED = 10'h3FF;
    w = 1; to = 0;
    forever begin
      @(negedge Clk_50MHz);
      if (button === 1'b1) break;
      w++;
      if (w >= 40) begin to = 1; break; end
    end
    if (to) begin
      check({tag, " rise_timeout"}, 32'd0, 32'd1);
      return;
    end
    check({tag, " width"}, w, PRESS);
    pcount = pcount + 8'd1;
    check({tag, " presses"}, presses, pcount);
    if (inject_lost) begin
      check({tag, " lost_sw"}, SW, 10'h000);
      check({tag, " lost_busy"}, busy, 1'b0);
    end else begin
      hold = 0;
      while (SW === exp_sw && hold < 40) begin
        hold++;
        @(negedge Clk_50MHz);
      end
      check({tag, " cooldown"}, hold, COOL);
      check({tag, " sw_idle"}, SW, 10'h000);
      check({tag, " busy_idle"}, busy, 1'b0);
    end
  endtask

  initial begin
    logic [9:0] t;
    bit         m, seen;
    int         n_rand, k;

    reset = 1'b0; enable = 1'b1; miss_mode = 1'b0; LED = 10'h000;
    repeat (3) @(negedge Clk_50MHz);
    check("reset SW", SW, 10'h000);
    check("reset button", button, 1'b1);
    check("reset presses", presses, 8'd0);
    check("reset busy", busy, 1'b0);

    // Static one-hot LED after reset is acquired.
    reset = 1'b1;
    LED   = 10'h001;
    observe_press("basic", 10'h001, 0, 0);

    // Complemented pattern; miss_mode changes mid-press must not matter.
    settle();
    miss_mode = 1'b1;
    LED = 10'h001;
    observe_press("miss", 10'h3FE, 0, 1);
    miss_mode = 1'b0;

    // Retarget arriving exactly as the first wait would have expired.
    settle();
    LED = 10'h001;
    k = 0;
    while (busy !== 1'b1 && k < 20) begin @(negedge Clk_50MHz); k++; end
    check("retarget wait_entry", k < 20, 1'b1);
    @(negedge Clk_50MHz);
    LED = 10'h002;
    observe_press("retarget", 10'h002, 0, 0);

    // Non-one-hot value is ignored.
    settle();
    LED = 10'h003;
    seen = 0;
    repeat (12) begin
      @(negedge Clk_50MHz);
      if (busy !== 1'b0) seen = 1;
    end
    check("non_onehot ignored", seen, 1'b0);

    // All-ones during a press: pulse completes, then LOST; recover on 0x004.
    settle();
    LED = 10'h010;
    observe_press("lost", 10'h010, 1, 0);
    repeat (3) @(negedge Clk_50MHz);
    check("lost hold SW", SW, 10'h000);
    check("lost hold button", button, 1'b1);
    check("lost hold busy", busy, 1'b0);
    LED = 10'h004;
    observe_press("after_lost", 10'h004, 0, 0);

    // enable dropped during SETUP.
    settle();
    LED = 10'h020;
    k = 0;
    while (SW === 10'h000 && k < 20) begin @(negedge Clk_50MHz); k++; end
    check("setup_drop reached", k < 20, 1'b1);
    enable = 1'b0;
    @(negedge Clk_50MHz);
    check("setup_drop SW", SW, 10'h000);
    check("setup_drop busy", busy, 1'b0);
    seen = 0;
    repeat (10) begin
      @(negedge Clk_50MHz);
      if (button !== 1'b1) seen = 1;
    end
    check("setup_drop no_press", seen, 1'b0);
    check("setup_drop presses", presses, pcount);
    enable = 1'b1;

    // Random targets and miss settings until the count wraps past 255.
    n_rand = 256 - int'(pcount);
    for (int i = 0; i < n_rand; i++) begin
      settle();
      t = 10'd1 << $urandom_range(0, 9);
      m = 1'($urandom_range(0, 1));
      miss_mode = m;
      LED = t;
      observe_press("rand", m ? ~t : t, 0, 0);
    end
    miss_mode = 1'b0;
    check("wrap presses", presses, 8'h00);

    // Reset mid-press takes effect without a clock edge.
    settle();
    LED = 10'h001;
    k = 0;
    while (button !== 1'b0 && k < 30) begin @(negedge Clk_50MHz); k++; end
    check("midpress reached", k < 30, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("midpress button", button, 1'b1);
    check("midpress SW", SW, 10'h000);
    check("midpress presses", presses, 8'h00);
    check("midpress busy", busy, 1'b0);
    repeat (2) @(negedge Clk_50MHz);
    reset = 1'b1;
    @(negedge Clk_50MHz);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
